// File: rtl/exec_int_writeback_if.sv
// Bundle between the issue stage / integer execute unit and the writeback block.
// The master side drives issue and execute results; the slave side is the writeback block.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

interface exec_int_writeback_if;
   logic              issue_valid;
   logic [4:0]        issue_rd;
   logic [`ALEN-1:0]  issue_addr;
   logic              issue_ready;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic              rs1_hazard;
   logic              rs2_hazard;
   logic              exec_valid;
   logic              exec_exception;
   logic [3:0]        exec_trap_cause;
   logic [`XLEN-1:0]  exec_result;
   logic              flush;
   logic              reg_write_en;
   logic [4:0]        reg_write_addr;
   logic [`XLEN-1:0]  reg_write_data;
   logic              trap_valid;
   logic [3:0]        trap_cause;
   logic [`ALEN-1:0]  trap_addr;
   logic              wb_error;

   modport slave (
      input  issue_valid, issue_rd, issue_addr, rs1, rs2,
             exec_valid, exec_exception, exec_trap_cause, exec_result, flush,
      output issue_ready, rs1_hazard, rs2_hazard,
             reg_write_en, reg_write_addr, reg_write_data,
             trap_valid, trap_cause, trap_addr, wb_error
   );

   modport master (
      output issue_valid, issue_rd, issue_addr, rs1, rs2,
             exec_valid, exec_exception, exec_trap_cause, exec_result, flush,
      input  issue_ready, rs1_hazard, rs2_hazard,
             reg_write_en, reg_write_addr, reg_write_data,
             trap_valid, trap_cause, trap_addr, wb_error
   );
endinterface

// File: rtl/exec_int_writeback.sv
// Integer writeback: in-order tag FIFO pairing issued {rd, addr} with execute results,
// registered register-file write / trap outputs, and RAW hazard flags for issue.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module exec_int_writeback #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   exec_int_writeback_if.slave  bus
);
   localparam int PTRW = $clog2(DEPTH);
   localparam logic [PTRW:0] PTR_ONE  = (PTRW+1)'(1);
   localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

   logic [PTRW:0]      r_wptr;
   logic [PTRW:0]      r_rptr;
   logic [4:0]         r_fifo_rd   [DEPTH];
   logic [`ALEN-1:0]   r_fifo_addr [DEPTH];

   logic               r_reg_write_en;
   logic [4:0]         r_reg_write_addr;
   logic [`XLEN-1:0]   r_reg_write_data;
   logic               r_trap_valid;
   logic [3:0]         r_trap_cause;
   logic [`ALEN-1:0]   r_trap_addr;
   logic               r_wb_error;

   logic [PTRW:0]      w_count;
   logic               w_empty;
   logic               w_full;
   logic               w_issue_ready;
   logic               w_push;
   logic               w_pop;
   logic               w_err;
   logic [4:0]         w_head_rd;
   logic [`ALEN-1:0]   w_head_addr;
   logic [DEPTH-1:0]   w_valid_mask;
   logic               w_rs1_hit;
   logic               w_rs2_hit;

   assign w_count       = r_wptr - r_rptr;
   assign w_empty       = (w_count == '0);
   assign w_full        = (w_count == FULL_CNT);
   assign w_issue_ready = !w_full || (bus.exec_valid && !w_empty);
   assign w_push        = bus.issue_valid && w_issue_ready && !bus.flush;
   assign w_pop         = bus.exec_valid && !w_empty && !bus.flush;
   assign w_err         = !bus.flush &&
                          ((bus.issue_valid && !w_issue_ready) || (bus.exec_valid && w_empty));
   assign w_head_rd     = r_fifo_rd[r_rptr[PTRW-1:0]];
   assign w_head_addr   = r_fifo_addr[r_rptr[PTRW-1:0]];

   // Occupied slots (including the head being popped) and source-register matches
   always_comb begin
      w_valid_mask = '0;
      w_rs1_hit    = 1'b0;
      w_rs2_hit    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_valid_mask[i] = ({1'b0, PTRW'(i) - r_rptr[PTRW-1:0]} < w_count);
         w_rs1_hit = w_rs1_hit | (w_valid_mask[i] && (r_fifo_rd[i] == bus.rs1));
         w_rs2_hit = w_rs2_hit | (w_valid_mask[i] && (r_fifo_rd[i] == bus.rs2));
      end
   end

   // A write leaving on the port this cycle is still a pending producer
   assign bus.rs1_hazard = (bus.rs1 != 5'd0) &&
                           (w_rs1_hit || (r_reg_write_en && (r_reg_write_addr == bus.rs1)));
   assign bus.rs2_hazard = (bus.rs2 != 5'd0) &&
                           (w_rs2_hit || (r_reg_write_en && (r_reg_write_addr == bus.rs2)));
   assign bus.issue_ready    = w_issue_ready;
   assign bus.reg_write_en   = r_reg_write_en;
   assign bus.reg_write_addr = r_reg_write_addr;
   assign bus.reg_write_data = r_reg_write_data;
   assign bus.trap_valid     = r_trap_valid;
   assign bus.trap_cause     = r_trap_cause;
   assign bus.trap_addr      = r_trap_addr;
   assign bus.wb_error       = r_wb_error;

   // Tag storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wptr[PTRW-1:0]]   <= bus.issue_rd;
         r_fifo_addr[r_wptr[PTRW-1:0]] <= bus.issue_addr;
      end
   end

   // Pointers, registered writeback/trap outputs and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr           <= '0;
         r_rptr           <= '0;
         r_reg_write_en   <= 1'b0;
         r_reg_write_addr <= 5'd0;
         r_reg_write_data <= '0;
         r_trap_valid     <= 1'b0;
         r_trap_cause     <= 4'd0;
         r_trap_addr      <= '0;
         r_wb_error       <= 1'b0;
      end else begin
         r_reg_write_en <= 1'b0;
         r_trap_valid   <= 1'b0;
         if (bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PTR_ONE;
               if (bus.exec_exception) begin
                  r_trap_valid <= 1'b1;
                  r_trap_cause <= bus.exec_trap_cause;
                  r_trap_addr  <= w_head_addr;
               end else if (w_head_rd != 5'd0) begin
                  r_reg_write_en   <= 1'b1;
                  r_reg_write_addr <= w_head_rd;
                  r_reg_write_data <= bus.exec_result;
               end
            end
            if (w_err) begin
               r_wb_error <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_exec_int_writeback.sv
// Directed bench for exec_int_writeback with hand-computed expectations.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module tb_exec_int_writeback;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   exec_int_writeback_if bif ();

   exec_int_writeback #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bif.issue_valid     = 1'b0;
      bif.issue_rd        = 5'd0;
      bif.issue_addr      = '0;
      bif.exec_valid      = 1'b0;
      bif.exec_exception  = 1'b0;
      bif.exec_trap_cause = 4'd0;
      bif.exec_result     = '0;
      bif.flush           = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [`ALEN-1:0] addr);
      bif.issue_valid = 1'b1;
      bif.issue_rd    = rd;
      bif.issue_addr  = addr;
   endtask

   task automatic result(input logic [`XLEN-1:0] data, input logic exc, input logic [3:0] cause);
      bif.exec_valid      = 1'b1;
      bif.exec_result     = data;
      bif.exec_exception  = exc;
      bif.exec_trap_cause = cause;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle_inputs();
      bif.rs1 = 5'd0;
      bif.rs2 = 5'd0;
      do_reset();

      // Reset state
      chk("rst_wen",    64'(bif.reg_write_en),   64'd0);
      chk("rst_waddr",  64'(bif.reg_write_addr), 64'd0);
      chk("rst_wdata",  64'(bif.reg_write_data), 64'd0);
      chk("rst_trap",   64'(bif.trap_valid),     64'd0);
      chk("rst_tcause", 64'(bif.trap_cause),     64'd0);
      chk("rst_taddr",  64'(bif.trap_addr),      64'd0);
      chk("rst_err",    64'(bif.wb_error),       64'd0);
      chk("rst_ready",  64'(bif.issue_ready),    64'd1);

      // Single ALU op rd=5, result 0x2A
      bif.rs1 = 5'd5;
      issue(5'd5, 32'h100);
      #1 chk("t1_haz_pre", 64'(bif.rs1_hazard), 64'd0);
      tick();
      idle_inputs();
      result(32'h2A, 1'b0, 4'd0);
      #1 chk("t1_haz_pend", 64'(bif.rs1_hazard), 64'd1);
      tick();
      idle_inputs();
      #1;
      chk("t1_wen",   64'(bif.reg_write_en),   64'd1);
      chk("t1_waddr", 64'(bif.reg_write_addr), 64'd5);
      chk("t1_wdata", 64'(bif.reg_write_data), 64'h2A);
      chk("t1_haz_wr", 64'(bif.rs1_hazard),    64'd1);
      tick();
      chk("t1_wen_off", 64'(bif.reg_write_en), 64'd0);
      chk("t1_haz_off", 64'(bif.rs1_hazard),   64'd0);

      // MUL rd=7 then ADD rd=8, results in order
      issue(5'd7, 32'h104);
      tick();
      idle_inputs();
      tick();
      issue(5'd8, 32'h108);
      result(32'h77, 1'b0, 4'd0);
      tick();
      idle_inputs();
      result(32'h88, 1'b0, 4'd0);
      #1;
      chk("t2_wen7",   64'(bif.reg_write_en),   64'd1);
      chk("t2_waddr7", 64'(bif.reg_write_addr), 64'd7);
      chk("t2_wdata7", 64'(bif.reg_write_data), 64'h77);
      tick();
      idle_inputs();
      chk("t2_wen8",   64'(bif.reg_write_en),   64'd1);
      chk("t2_waddr8", 64'(bif.reg_write_addr), 64'd8);
      chk("t2_wdata8", 64'(bif.reg_write_data), 64'h88);
      chk("t2_err",    64'(bif.wb_error),       64'd0);

      // Exception on rd=3
      issue(5'd3, 32'h200);
      tick();
      idle_inputs();
      result(32'hDEAD, 1'b1, 4'd2);
      tick();
      idle_inputs();
      chk("t3_trap",   64'(bif.trap_valid),   64'd1);
      chk("t3_cause",  64'(bif.trap_cause),   64'd2);
      chk("t3_taddr",  64'(bif.trap_addr),    64'h200);
      chk("t3_nowr",   64'(bif.reg_write_en), 64'd0);
      tick();
      chk("t3_trap_off", 64'(bif.trap_valid), 64'd0);

      // Fill to DEPTH, push+pop while full, overflow
      for (int i = 0; i < 4; i++) begin
         issue(5'(10 + i), 32'h300 + 32'(4 * i));
         tick();
      end
      idle_inputs();
      #1 chk("t4_full_ready", 64'(bif.issue_ready), 64'd0);
      issue(5'd14, 32'h310);
      result(32'hA0, 1'b0, 4'd0);
      #1 chk("t4_pp_ready", 64'(bif.issue_ready), 64'd1);
      tick();
      idle_inputs();
      bif.rs1 = 5'd14;
      bif.rs2 = 5'd10;
      #1;
      chk("t4_still_full", 64'(bif.issue_ready),    64'd0);
      chk("t4_waddr",      64'(bif.reg_write_addr), 64'd10);
      chk("t4_haz14",      64'(bif.rs1_hazard),     64'd1);
      chk("t4_haz10_wr",   64'(bif.rs2_hazard),     64'd1);
      chk("t4_err_pre",    64'(bif.wb_error),       64'd0);
      issue(5'd15, 32'h314);
      tick();
      idle_inputs();
      chk("t4_err",      64'(bif.wb_error),   64'd1);
      chk("t4_haz10_off", 64'(bif.rs2_hazard), 64'd0);
      for (int i = 0; i < 4; i++) begin
         result(32'hB1 + 32'(i), 1'b0, 4'd0);
         tick();
      end
      idle_inputs();
      chk("t4_last_addr", 64'(bif.reg_write_addr), 64'd14);
      chk("t4_last_data", 64'(bif.reg_write_data), 64'hB4);
      do_reset();
      #1 chk("t4_err_rst", 64'(bif.wb_error), 64'd0);

      // rd=0 never writes and never flags a hazard
      bif.rs1 = 5'd0;
      issue(5'd0, 32'h400);
      #1 chk("t5_haz_a", 64'(bif.rs1_hazard), 64'd0);
      tick();
      idle_inputs();
      result(32'hFFFF, 1'b0, 4'd0);
      #1 chk("t5_haz_b", 64'(bif.rs1_hazard), 64'd0);
      tick();
      idle_inputs();
      chk("t5_nowr", 64'(bif.reg_write_en), 64'd0);
      chk("t5_err",  64'(bif.wb_error),     64'd0);

      // Two pending entries with the same rd: hazard until the last pops
      bif.rs1 = 5'd9;
      issue(5'd9, 32'h500);
      tick();
      issue(5'd9, 32'h504);
      tick();
      idle_inputs();
      result(32'h91, 1'b0, 4'd0);
      tick();
      idle_inputs();
      chk("t7_haz_one_left", 64'(bif.rs1_hazard), 64'd1);
      result(32'h92, 1'b0, 4'd0);
      tick();
      idle_inputs();
      chk("t7_haz_wr", 64'(bif.rs1_hazard), 64'd1);
      tick();
      chk("t7_haz_off", 64'(bif.rs1_hazard), 64'd0);

      // Flush with two pending entries
      bif.rs1 = 5'd20;
      bif.rs2 = 5'd21;
      issue(5'd20, 32'h600);
      tick();
      issue(5'd21, 32'h604);
      tick();
      idle_inputs();
      #1;
      chk("t6_haz1_pre", 64'(bif.rs1_hazard), 64'd1);
      chk("t6_haz2_pre", 64'(bif.rs2_hazard), 64'd1);
      bif.flush = 1'b1;
      tick();
      idle_inputs();
      chk("t6_haz1", 64'(bif.rs1_hazard),   64'd0);
      chk("t6_haz2", 64'(bif.rs2_hazard),   64'd0);
      chk("t6_nowr", 64'(bif.reg_write_en), 64'd0);
      chk("t6_err_pre", 64'(bif.wb_error),  64'd0);
      result(32'h55, 1'b0, 4'd0);
      tick();
      idle_inputs();
      chk("t6_err",   64'(bif.wb_error),     64'd1);
      chk("t6_nowr2", 64'(bif.reg_write_en), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
